// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : div_pkg                                                      |
// | Description : Shared types and constants for the sequential signed divider |
// |               (state encoding, default operand width, special values).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package div_pkg;

    // Default operand / quotient / remainder width of the execute-stage datapath.
    localparam int c_default_width = 64;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Special values at the default width: most-negative integer and -1.
    localparam logic [c_default_width-1:0] c_most_neg = {1'b1, {(c_default_width-1){1'b0}}};
    localparam logic [c_default_width-1:0] c_all_ones = {c_default_width{1'b1}};

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_step                                                     |
// | Description : One restoring shift-subtract step on unsigned magnitudes.    |
// |               Shifts the next dividend bit into the partial remainder and  |
// |               subtracts the divisor magnitude when it fits.                |
// | Ports       : prem_in  - partial remainder (WIDTH+1 bits)                  |
// |               dvd_bit  - next dividend bit, MSB first                      |
// |               dsr_mag  - divisor magnitude                                 |
// |               prem_out - updated partial remainder                         |
// |               q_bit    - quotient bit produced by this step                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH:0]   prem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr_mag,
    output logic [WIDTH:0]   prem_out,
    output logic             q_bit
);

    logic [WIDTH:0] w_shifted;
    logic           w_fits;

    // The bit shifted out of the top can only be set if the shifted value
    // exceeds 2^(WIDTH+1) > divisor, so it forces "fits"; the difference is
    // then below the divisor and the truncated subtraction stays exact.
    assign w_shifted = {prem_in[WIDTH-1:0], dvd_bit};
    assign w_fits    = prem_in[WIDTH] | (w_shifted >= {1'b0, dsr_mag});
    assign prem_out  = w_fits ? (w_shifted - {1'b0, dsr_mag}) : w_shifted;
    assign q_bit     = w_fits;

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_divider                                                  |
// | Description : Multi-cycle signed integer divider, one quotient bit per     |
// |               cycle (restoring), truncating toward zero, with sign fix-up  |
// |               and single-cycle handling of divide-by-zero and overflow.    |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               start           - request, accepted only in IDLE             |
// |               dividend/divisor- signed operands, sampled with start        |
// |               busy            - high while not IDLE                        |
// |               done            - one-cycle result-valid pulse               |
// |               quotient/remainder - registered signed results              |
// |               div_by_zero/overflow - flags of the last completed operation |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               c_cnt_w   = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_min_val = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_neg_one = {WIDTH{1'b1}};

    div_state_t          r_state;
    div_state_t          w_state_next;
    logic [WIDTH:0]      r_prem;      // partial remainder magnitude
    logic [WIDTH-1:0]    r_shreg;     // dividend bits out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0]    r_dsr_mag;
    logic                r_q_neg;
    logic                r_r_neg;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_is_dz;
    logic                w_is_ov;
    logic                w_last;
    logic [WIDTH:0]      w_prem_next;
    logic                w_q_bit;
    logic [WIDTH-1:0]    w_q_mag;
    logic [WIDTH-1:0]    w_r_mag;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign w_is_dz = (divisor == '0);
    assign w_is_ov = (dividend == c_min_val) && (divisor == c_neg_one);
    assign w_last  = (r_cnt == c_last);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem_in  (r_prem),
        .dvd_bit  (r_shreg[WIDTH-1]),
        .dsr_mag  (r_dsr_mag),
        .prem_out (w_prem_next),
        .q_bit    (w_q_bit)
    );

    // Results of the final iteration, used directly for the DONE-entry fix-up.
    assign w_q_mag = {r_shreg[WIDTH-2:0], w_q_bit};
    assign w_r_mag = w_prem_next[WIDTH-1:0];

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (w_is_dz || w_is_ov) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prem      <= '0;
            r_shreg     <= '0;
            r_dsr_mag   <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_prem      <= '0;
                        r_shreg     <= abs_val(dividend);
                        r_dsr_mag   <= abs_val(divisor);
                        r_q_neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_r_neg     <= dividend[WIDTH-1];
                        r_cnt       <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        // Divide-by-zero is tested first so it wins over overflow.
                        if (w_is_dz) begin
                            quotient    <= c_neg_one;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else if (w_is_ov) begin
                            quotient    <= c_min_val;
                            remainder   <= '0;
                            overflow    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_prem  <= w_prem_next;
                    r_shreg <= w_q_mag;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        quotient  <= r_q_neg ? -w_q_mag : w_q_mag;
                        remainder <= r_r_neg ? -w_r_mag : w_r_mag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seq_divider
`default_nettype wire
